// File: rtl/sign_resolver.sv
// sign_resolver: pairs in-order sign tags from the sign logic with adder
// magnitude results and produces the final sign of the sum.
//
// Tags {s_tmp, final_m[, rm]} are queued in a DEPTH-entry FIFO on the issue
// side. Each accepted adder result pops the head tag, resolves the sign and
// registers it into a one-entry output stage.
//
// Optional feature macro: SIGN_ZERO_RM_EN
//   defined   : rounding mode is stored with each tag, and an exact-zero
//               effective-subtraction result takes sign 1 under RDN (3'b010).
//   undefined : rm is not stored (tag is 2 bits) and that case is always +0.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// Once valid is raised it is held, with its payload, until that transfer.
// ready never depends on the valid of the same interface.
module sign_resolver #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic                     iss_s_tmp,
  input  logic                     iss_final_m,
  input  logic [2:0]               iss_rm,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     res_borrow,
  input  logic                     res_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

`ifdef SIGN_ZERO_RM_EN
  localparam int TW = 5;
`else
  localparam int TW = 2;
`endif

  // Tag storage; bit 0 = s_tmp, bit 1 = final_m, bits 4:2 = rm when stored.
  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  logic          push;
  logic          pop;
  logic [TW-1:0] wr_tag;
  logic [TW-1:0] head;
  logic          head_s_tmp;
  logic          head_final_m;
  logic          zero_sign;
  logic          res_sign;

  // Pack the incoming tag; rm is only kept when the zero-sign feature is on.
`ifdef SIGN_ZERO_RM_EN
  assign wr_tag = {iss_rm, iss_final_m, iss_s_tmp};
`else
  assign wr_tag = {iss_final_m, iss_s_tmp};
  logic unused_rm;
  assign unused_rm = ^iss_rm;
`endif

  // Ready terms come straight from registered state. iss_ready ignores a
  // same-cycle pop on purpose so a full buffer never accepts a tag.
  assign iss_ready = (occupancy < FULL_LEVEL);
  assign res_ready = (occupancy != '0) && (!out_valid || out_ready);

  assign push = iss_valid && iss_ready;
  assign pop  = res_valid && res_ready;

  // Resolve the sign of the current result against the head tag.
  always_comb begin
    head         = mem[rptr];
    head_s_tmp   = head[0];
    head_final_m = head[1];
`ifdef SIGN_ZERO_RM_EN
    zero_sign    = (head[4:2] == 3'b010);
`else
    zero_sign    = 1'b0;
`endif
    if (head_final_m) begin
      res_sign = head_s_tmp;
    end else if (res_zero) begin
      res_sign = zero_sign;
    end else begin
      res_sign = head_s_tmp ^ res_borrow;
    end
  end

  // Tag RAM write; contents need no reset because occupancy gates all reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wr_tag;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // One-entry output stage: load on a result handshake, drain on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_sign  <= res_sign;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sign_resolver.sv
// Bench for sign_resolver: directed steps plus a random phase, all compared
// against a queue-based reference model of tags and the output stage.
module tb_sign_resolver;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   iss_valid;
  logic                   iss_ready;
  logic                   iss_s_tmp;
  logic                   iss_final_m;
  logic [2:0]             iss_rm;
  logic                   res_valid;
  logic                   res_ready;
  logic                   res_borrow;
  logic                   res_zero;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sign;
  logic [$clog2(DEPTH):0] occupancy;

  int total = 0;
  int bad   = 0;

  // Reference model state: queued tags {rm, final_m, s_tmp} and output stage.
  logic [4:0] exp_q[$];
  logic       m_ov = 1'b0;
  logic       m_os = 1'b0;

  sign_resolver #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_s_tmp   (iss_s_tmp),
    .iss_final_m (iss_final_m),
    .iss_rm      (iss_rm),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_borrow  (res_borrow),
    .res_zero    (res_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .occupancy   (occupancy)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Final sign of a sum from the tag and the adder result flags.
  function automatic logic ref_sign(input logic [4:0] t, input logic b, input logic z);
    if (t[1]) return t[0];
    if (!z) return t[0] ^ b;
`ifdef SIGN_ZERO_RM_EN
    return (t[4:2] == 3'b010);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_zero_rdn();
`ifdef SIGN_ZERO_RM_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive inputs, check readies, step the model, check outputs.
  task automatic cycle(input logic iv, input logic s, input logic fm, input logic [2:0] rm,
                       input logic rv, input logic b, input logic z, input logic ordy);
    logic m_ir, m_rr, do_pop, do_push;
    logic [4:0] t;
    iss_valid   = iv;
    iss_s_tmp   = s;
    iss_final_m = fm;
    iss_rm      = rm;
    res_valid   = rv;
    res_borrow  = b;
    res_zero    = z;
    out_ready   = ordy;
    #1;
    m_ir = (exp_q.size() < DEPTH);
    m_rr = (exp_q.size() != 0) && (!m_ov || ordy);
    check("iss_ready", 32'(iss_ready), 32'(m_ir));
    check("res_ready", 32'(res_ready), 32'(m_rr));
    do_pop  = rv && m_rr;
    do_push = iv && m_ir;
    if (do_pop) begin
      t = exp_q.pop_front();
      m_os = ref_sign(t, b, z);
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (do_push) exp_q.push_back({rm, fm, s});
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_sign", 32'(out_sign), 32'(m_os));
    check("occupancy", 32'(occupancy), 32'(exp_q.size()));
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  task automatic push_tag(input logic s, input logic fm, input logic [2:0] rm);
    cycle(1'b1, s, fm, rm, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic give_res(input logic b, input logic z, input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, b, z, ordy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iss_ready"}, 32'(iss_ready), 32'd1);
    check({tag, "_res_ready"}, 32'(res_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_sign"}, 32'(out_sign), 32'd0);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
  endtask

  // Directed and random stimulus
  initial begin
    rst_n = 1'b0;
    iss_valid = 1'b0; iss_s_tmp = 1'b0; iss_final_m = 1'b0; iss_rm = 3'b000;
    res_valid = 1'b0; res_borrow = 1'b0; res_zero = 1'b0; out_ready = 1'b1;
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // final_m=1 keeps s_tmp regardless of borrow; valid one cycle after handshake
    push_tag(1'b1, 1'b1, 3'b000);
    give_res(1'b1, 1'b0, 1'b1);
    check("final_m_sign", 32'(out_sign), 32'd1);
    check("final_m_valid", 32'(out_valid), 32'd1);

    // borrow flips the tentative sign
    push_tag(1'b0, 1'b0, 3'b000);
    give_res(1'b1, 1'b0, 1'b1);
    check("borrow_0", 32'(out_sign), 32'd1);
    push_tag(1'b1, 1'b0, 3'b000);
    give_res(1'b1, 1'b0, 1'b1);
    check("borrow_1", 32'(out_sign), 32'd0);

    // exact zero: RDN dependent only when the feature is built in
    push_tag(1'b1, 1'b0, 3'b010);
    give_res(1'b0, 1'b1, 1'b1);
    check("zero_rdn", 32'(out_sign), 32'(exp_zero_rdn()));
    push_tag(1'b1, 1'b0, 3'b000);
    give_res(1'b0, 1'b1, 1'b1);
    check("zero_rne", 32'(out_sign), 32'd0);
    idle(1'b1);

    // fill to DEPTH, then a pop while iss_valid is high must not push
    for (int i = 0; i < DEPTH; i++) push_tag(1'(i), 1'b1, 3'b000);
    check("full_iss_ready", 32'(iss_ready), 32'd0);
    check("full_occ", 32'(occupancy), 32'(DEPTH));
    cycle(1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    check("full_pop_occ", 32'(occupancy), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) give_res(1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // output back-pressure holds the stage and blocks results
    push_tag(1'b1, 1'b1, 3'b000);
    push_tag(1'b0, 1'b1, 3'b000);
    give_res(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      give_res(1'b0, 1'b0, 1'b0);
      check("bp_res_ready", 32'(res_ready), 32'd0);
      check("bp_sign_held", 32'(out_sign), 32'd1);
    end
    // release: one result per cycle for 8 tags, alternating signs keep order visible
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'(i), 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
      check("stream_valid", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < DEPTH + 1; i++) give_res(1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) give_res(1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // asynchronous reset mid-operation: occupancy 3, output pending
    for (int i = 0; i < DEPTH; i++) push_tag(1'b1, 1'b1, 3'b000);
    give_res(1'b0, 1'b0, 1'b1);
    check("pre_rst_occ", 32'(occupancy), 32'd3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    iss_valid = 1'b0; res_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    m_ov = 1'b0;
    m_os = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_occ", 32'(occupancy), 32'd0);
    give_res(1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check("post_rst_no_out", 32'(out_valid), 32'd0);
    push_tag(1'b0, 1'b0, 3'b000);
    give_res(1'b1, 1'b0, 1'b1);
    check("post_rst_sign", 32'(out_sign), 32'd1);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
